// File: rtl/cla_pipe_subtractor.sv
// Pipelined subtractor: diff = a - b - bin, modulo 2^WIDTH.
// Computed as a + ~b + ~bin. The word is split into BLOCK-bit slices; each
// pipeline stage resolves one slice with carry-look-ahead logic and registers
// its carry-out for the next stage, so no carry crosses a slice boundary
// within a cycle. Results come out STAGES cycles after acceptance.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   in_valid  operands present       in_ready  operands accepted this cycle
//   a, b, bin minuend, subtrahend, borrow in
//   out_valid result present         out_ready downstream accepts result
//   diff      a - b - bin            bout      unsigned borrow out
//   ovf       signed overflow
module cla_pipe_subtractor #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned STAGES = WIDTH / BLOCK;

  // Per-stage registers. Operands and carries are only needed by the stage
  // that follows, so the last stage has none.
  logic [STAGES-1:0] vld_q;
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  opa_q [STAGES-1];
  logic [WIDTH-1:0]  opb_q [STAGES-1];
  logic [STAGES-2:0] cy_q;
  logic              bout_q;
  logic              ovf_q;

  // Per-stage combinational slice results.
  logic [BLOCK-1:0]  slice_a   [STAGES];
  logic [BLOCK-1:0]  slice_b   [STAGES];
  logic [BLOCK-1:0]  slice_s   [STAGES];
  logic [WIDTH-1:0]  sum_nxt   [STAGES];
  logic [STAGES-1:0] slice_ci;
  logic [STAGES-1:0] slice_co;
  logic              msb_ci;
  logic              adv;

  // The whole pipe moves as one; a stall freezes every stage.
  assign adv      = ~vld_q[STAGES-1] | out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] p;
    logic [BLOCK:0]   c;
    logic             pp;

    if (k == 0) begin : g_first
      assign slice_a[k]  = a[BLOCK-1:0];
      assign slice_b[k]  = ~b[BLOCK-1:0];
      assign slice_ci[k] = ~bin;
      assign sum_nxt[k]  = {{(WIDTH-BLOCK){1'b0}}, slice_s[k]};
    end else begin : g_rest
      assign slice_a[k]  = opa_q[k-1][k*BLOCK +: BLOCK];
      assign slice_b[k]  = opb_q[k-1][k*BLOCK +: BLOCK];
      assign slice_ci[k] = cy_q[k-1];
      if (k == STAGES - 1) begin : g_top
        assign sum_nxt[k] = {slice_s[k], sum_q[k-1][k*BLOCK-1:0]};
      end else begin : g_mid
        assign sum_nxt[k] = {sum_q[k-1][WIDTH-1:(k+1)*BLOCK], slice_s[k],
                             sum_q[k-1][k*BLOCK-1:0]};
      end
    end

    // Flattened look-ahead: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]c[0].
    always_comb begin
      g  = slice_a[k] & slice_b[k];
      p  = slice_a[k] ^ slice_b[k];
      c  = '0;
      pp = 1'b0;
      c[0] = slice_ci[k];
      for (int i = 0; i < BLOCK; i++) begin
        c[i+1] = g[i];
        pp     = p[i];
        for (int j = i - 1; j >= 0; j--) begin
          c[i+1] = c[i+1] | (pp & g[j]);
          pp     = pp & p[j];
        end
        c[i+1] = c[i+1] | (pp & c[0]);
      end
    end

    assign slice_s[k]  = p ^ c[BLOCK-1:0];
    assign slice_co[k] = c[BLOCK];

    if (k == STAGES - 1) begin : g_msb
      assign msb_ci = c[BLOCK-1];
    end
  end

  // Data registers only load behind a valid entry, so bubbles leave the
  // previous contents alone and a reset leaves zeros on the outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q  <= '0;
      cy_q   <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k] <= '0;
      end
      for (int k = 0; k < STAGES - 1; k++) begin
        opa_q[k] <= '0;
        opb_q[k] <= '0;
      end
    end else if (adv) begin
      vld_q <= {vld_q[STAGES-2:0], in_valid};
      if (in_valid) begin
        sum_q[0] <= sum_nxt[0];
        opa_q[0] <= a;
        opb_q[0] <= ~b;
        cy_q[0]  <= slice_co[0];
      end
      for (int k = 1; k < STAGES - 1; k++) begin
        if (vld_q[k-1]) begin
          sum_q[k] <= sum_nxt[k];
          opa_q[k] <= opa_q[k-1];
          opb_q[k] <= opb_q[k-1];
          cy_q[k]  <= slice_co[k];
        end
      end
      if (vld_q[STAGES-2]) begin
        sum_q[STAGES-1] <= sum_nxt[STAGES-1];
        bout_q          <= ~slice_co[STAGES-1];
        ovf_q           <= msb_ci ^ slice_co[STAGES-1];
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign diff      = sum_q[STAGES-1];
  assign bout      = bout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_pipe_subtractor.sv
// Self-checking bench for cla_pipe_subtractor (WIDTH=16, BLOCK=4).
module tb_cla_pipe_subtractor;

  typedef struct packed {
    logic [15:0] d;
    logic        bo;
    logic        ov;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    exp_t        e;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   retired  = 0;
  logic chk_lat  = 1'b0;
  logic [7:0] hist = '0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t vt[9];

  cla_pipe_subtractor #(
    .WIDTH(16),
    .BLOCK(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .bout     (bout),
    .ovf      (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic c);
    exp_t e;
    int   r;
    e.d  = x - y - {15'b0, c};
    e.bo = ({1'b0, x} < ({1'b0, y} + {16'b0, c}));
    r    = int'($signed(x)) - int'($signed(y)) - int'(c);
    e.ov = (r > 32767) || (r < -32768);
    return e;
  endfunction

  function automatic vec_t mk(input logic [15:0] x, input logic [15:0] y, input logic c,
                              input logic [15:0] d, input logic bo, input logic ov);
    vec_t v;
    v.a    = x;
    v.b    = y;
    v.bin  = c;
    v.e.d  = d;
    v.e.bo = bo;
    v.e.ov = ov;
    return v;
  endfunction

  // Drive one operand set; push the expectation on the accepting edge.
  task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic tbin,
                      input exp_t e);
    int tries = 0;
    @(negedge clk);
    #1;
    in_valid = 1'b1;
    a        = ta;
    b        = tb;
    bin      = tbin;
    while (1) begin
      #1;
      if (in_ready) begin
        sb.push_back(e);
        @(posedge clk);
        break;
      end
      @(negedge clk);
      #1;
      tries++;
      if (tries > 200) begin
        check("accept_timeout", 32'(in_ready), 32'd1);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    @(negedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: samples 1 time unit before each rising edge.
  always begin
    @(negedge clk);
    #4;
    if (!rst_n) begin
      sb.delete();
      hist = '0;
    end else begin
      if (chk_lat) check("latency_out_valid", 32'(out_valid), 32'(hist[3]));
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 32'(out_valid), 32'd0);
        end else begin
          mon_e = sb[0];
          check("diff", 32'(diff), 32'(mon_e.d));
          check("bout", 32'(bout), 32'(mon_e.bo));
          check("ovf", 32'(ovf), 32'(mon_e.ov));
          if (out_ready) begin
            void'(sb.pop_front());
            retired++;
          end
        end
      end
      hist = {hist[6:0], in_valid & in_ready};
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    out_ready = 1'b1;

    vt[0] = mk(16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0);
    vt[1] = mk(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    vt[2] = mk(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    vt[3] = mk(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
    vt[4] = mk(16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    vt[5] = mk(16'h0010, 16'h0001, 1'b1, 16'h000E, 1'b0, 1'b0);
    vt[6] = mk(16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    vt[7] = mk(16'h8000, 16'h7FFF, 1'b0, 16'h0001, 1'b0, 1'b1);
    vt[8] = mk(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0);

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n   = 1'b1;
    chk_lat = 1'b1;

    // First vector alone: out_valid for one cycle, four cycles later.
    send(vt[0].a, vt[0].b, vt[0].bin, vt[0].e);
    idle(8);
    // Remaining table back-to-back.
    for (int i = 1; i < 9; i++) send(vt[i].a, vt[i].b, vt[i].bin, vt[i].e);
    drain();

    // Backpressure: 8 back-to-back, out_ready low 3 cycles after 2nd result.
    chk_lat = 1'b0;
    retired = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send(16'(i * 16'h1111), 16'(i), 1'b0, model(16'(i * 16'h1111), 16'(i), 1'b0));
        end
        @(negedge clk);
        #1;
        in_valid = 1'b0;
      end
      begin
        wait (retired == 2);
        @(negedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          #1;
          check("stall_in_ready", 32'(in_ready), 32'd0);
          check("stall_out_valid", 32'(out_valid), 32'd1);
          @(negedge clk);
          #1;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
          #1;
          check("no_gap_out_valid", 32'(out_valid), 32'd1);
          @(negedge clk);
          #1;
        end
      end
    join
    drain();
    check("bp_retired", 32'(retired), 32'd8);
    idle(5);

    // Bubbles: alternating in_valid, latency pattern checked by the monitor.
    chk_lat = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(16'(16'h0F0F + i * 16'h0321), 16'(16'h7000 - i * 16'h0777), 1'(i % 2),
           model(16'(16'h0F0F + i * 16'h0321), 16'(16'h7000 - i * 16'h0777), 1'(i % 2)));
      idle(1);
    end
    drain();
    idle(2);

    // Reset with three results in flight.
    send(16'h1111, 16'h0101, 1'b0, model(16'h1111, 16'h0101, 1'b0));
    send(16'h2468, 16'h8642, 1'b1, model(16'h2468, 16'h8642, 1'b1));
    send(16'hF00D, 16'h0BAD, 1'b0, model(16'hF00D, 16'h0BAD, 1'b0));
    @(negedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_diff", 32'(diff), 32'd0);
    check("midrst_bout", 32'(bout), 32'd0);
    check("midrst_ovf", 32'(ovf), 32'd0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("postrst_out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      #1;
    end
    send(16'h4321, 16'h1234, 1'b1, model(16'h4321, 16'h1234, 1'b1));
    drain();
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cla_pipe_subtractor.md
Name: cla_pipe_subtractor

Overview:
Pipelined N-bit subtractor computing diff = a - b - bin, the inverse of the team's carry-look-ahead adder. The operand word is split into BLOCK-bit slices. Each slice is one CLA stage working on a + ~b with carry-in ~bin, and the carry is registered between stages. The block sits in the arithmetic datapath with valid/ready handshakes on both sides and full backpressure support.

Parameters:
WIDTH, 16, operand and result width in bits; must be a multiple of BLOCK.
BLOCK, 4, slice width per pipeline stage; STAGES = WIDTH/BLOCK.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  synchronous, active-low reset.
in_valid  input  1  operands present.
in_ready  output  1  block accepts operands this cycle.
a  input  WIDTH  minuend.
b  input  WIDTH  subtrahend.
bin  input  1  borrow in.
out_valid  output  1  result present.
out_ready  input  1  downstream accepts result.
diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
bout  output  1  borrow out; 1 when unsigned a < b + bin.
ovf  output  1  two's-complement overflow of the signed subtraction.

Behaviour:
- Reset is sampled on the rising clk edge only. While rst_n=0:
  - all stage valid bits clear;
  - all data and carry registers clear;
  - out_valid=0, diff=0, bout=0, ovf=0.
- Reset mid-operation discards every in-flight result; nothing emerges after reset deasserts.
- Pipeline advance: adv = ~out_valid | out_ready. in_ready = adv (combinational).
- Acceptance: an input is accepted on an edge where in_valid & in_ready.
- Stalls: when adv=0, all stage registers hold, including valid bits and partial sums.
- Bubbles travel with the stream. With out_ready held at 1, stages are not collapsed.
- Stage 0, on acceptance:
  - computes slice [BLOCK-1:0] of a + ~b + ~bin with CLA generate/propagate logic;
  - registers the slice sum and the slice carry-out;
  - registers the unprocessed upper bits of a and ~b.
- Stage k (1..STAGES-1) computes slice k from the carried operands and the registered carry of stage k-1. Lower slice results move forward unchanged.
- Final stage output registers drive diff, bout and ovf:
  - bout = ~carry_out of the MSB slice;
  - ovf = carry into MSB XOR carry out of MSB.
- Latency: exactly STAGES cycles from the accepting edge to out_valid=1, with no stalls (4 cycles at the defaults).
- Throughput: one result per cycle while out_ready=1.
- Ordering: results emerge in acceptance order. No result is dropped or duplicated under any out_ready pattern.
- Holding rule: diff, bout and ovf stay stable while out_valid=1 and out_ready=0.
- Simultaneous events: with out_valid=1 and out_ready=1 and in_valid=1, output retire and input accept happen on the same edge.
- Bubble with acceptance: when in_valid=0 and adv=1, a bubble (valid=0) enters stage 0.
- Combinational paths: there is no combinational path from a, b or bin to any output. in_ready depends only on out_valid and out_ready.
- Width rule: all arithmetic is modulo 2^WIDTH. Carries never cross a slice boundary within a cycle.

Test Plan:
- Reset, then a=0x1234, b=0x0034, bin=0, out_ready=1 -> 4 cycles later diff=0x1200, bout=0, ovf=0, out_valid high for 1 cycle.
- Borrow and overflow checks, one per result:
  - a=0x0000, b=0x0001 -> diff=0xFFFF, bout=1, ovf=0;
  - a=0x8000, b=0x0001 -> diff=0x7FFF, bout=0, ovf=1;
  - a=0x7FFF, b=0xFFFF -> diff=0x8000, bout=1, ovf=1.
- bin=1 with a=0x0005, b=0x0005 -> diff=0xFFFF, bout=1, ovf=0. bin=1 with a=0x0010, b=0x0001 -> diff=0x000E, bout=0.
- Backpressure: stream 8 back-to-back pairs a=i*0x1111, b=i; drop out_ready for 3 cycles after the second result.
  - Expected: in_ready=0 during the stall while the pipe is full; outputs held stable; all 8 results correct and in order; no gaps once out_ready returns.
- Bubbles: in_valid alternating 1/0 with out_ready=1 -> out_valid alternates with the same pattern 4 cycles later.
- Reset mid-operation: assert rst_n=0 for 1 cycle with 3 results in flight -> out_valid=0 the next cycle and stays 0 until new inputs have had 4 cycles to propagate; diff, bout and ovf read 0 after reset.
